mac_operand_feeder: RTL

- Upstream stage of the 32-bit MAC unit.
- Buffers incoming operand pairs (A, B) in a small FIFO and groups them into vectors delimited by a last flag.
- Clears the MAC accumulator at each vector start and streams pairs into the MAC at one pair per cycle.
- After the MAC pipeline drains, captures the 64-bit accumulator and presents it downstream with a valid/ready handshake.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_feeder_fifo.sv | 68 ++++++
 rtl/mac_operand_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC operand feeder.
package mac_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic                  last;
    } operand_pair_t;

endpackage

// File: rtl/mac_feeder_fifo.sv
// Small synchronous FIFO of operand pairs; head entry is readable in the same cycle it is popped.
module mac_feeder_fifo
    import mac_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type pair_t = operand_pair_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  pair_t wr_data,
    input  logic  pop,
    output pair_t rd_data,
    output logic  empty,
    output logic  ready
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pair_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             ready_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign ready   = ready_reg;
    // Register-file style head read so a pair can be popped and issued in one cycle.
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs, streams each vector into the MAC and captures the drained accumulator.
// Optional zero-skip (operand pairs with a zero factor are counted but not issued): MAC_FEEDER_ZSKIP_EN.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [LEN_W-1:0]  res_count
);

    localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              last;
    } pair_t;

    feeder_state_t      state_reg, state_next;
    logic [LEN_W-1:0]   term_cnt_reg, term_cnt_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [DATA_W-1:0]  mac_a_reg, mac_a_next;
    logic [DATA_W-1:0]  mac_b_reg, mac_b_next;
    logic               mac_en_reg, mac_en_next;
    logic               mac_clr_reg, mac_clr_next;
    logic               res_valid_reg, res_valid_next;
    logic [ACC_W-1:0]   res_data_reg, res_data_next;
    logic [LEN_W-1:0]   res_count_reg, res_count_next;

    pair_t in_pair;
    pair_t head;
    logic  fifo_empty;
    logic  fifo_ready;
    logic  pop;
    logic  issue;

    assign in_pair = '{a: s_a, b: s_b, last: s_last};

    mac_feeder_fifo #(
        .DEPTH  (DEPTH),
        .pair_t (pair_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s_valid && fifo_ready),
        .wr_data (in_pair),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .ready   (fifo_ready)
    );

`ifdef MAC_FEEDER_ZSKIP_EN
    assign issue = (head.a != '0) && (head.b != '0);
`else
    assign issue = 1'b1;
`endif

    always_comb begin
        state_next     = state_reg;
        term_cnt_next  = term_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        mac_a_next     = '0;
        mac_b_next     = '0;
        mac_en_next    = 1'b0;
        mac_clr_next   = 1'b0;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        res_count_next = res_count_reg;
        pop            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mac_clr_next  = 1'b1;
                    term_cnt_next = '0;
                    state_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    term_cnt_next = (term_cnt_reg == '1) ? term_cnt_reg : term_cnt_reg + 1'b1;
                    if (issue) begin
                        mac_en_next = 1'b1;
                        mac_a_next  = head.a;
                        mac_b_next  = head.b;
                    end
                    if (head.last) begin
                        drain_cnt_next = DRAIN_W'(MAC_LAT);
                        state_next     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Zero count means the last term has reached acc_in this cycle.
                if (drain_cnt_reg == '0) begin
                    res_data_next  = acc_in;
                    res_count_next = term_cnt_reg;
                    res_valid_next = 1'b1;
                    state_next     = ST_HOLD;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            term_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            mac_a_reg     <= '0;
            mac_b_reg     <= '0;
            mac_en_reg    <= 1'b0;
            mac_clr_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            term_cnt_reg  <= term_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            mac_a_reg     <= mac_a_next;
            mac_b_reg     <= mac_b_next;
            mac_en_reg    <= mac_en_next;
            mac_clr_reg   <= mac_clr_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_count_reg <= res_count_next;
        end
    end

    assign s_ready   = fifo_ready;
    assign mac_a     = mac_a_reg;
    assign mac_b     = mac_b_reg;
    assign mac_en    = mac_en_reg;
    assign mac_clr   = mac_clr_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_count = res_count_reg;

endmodule
